// File: rtl/vx_ahb_pkg.sv
// Shared AHB-Lite encodings and the subordinate state machine states for the
// AHB-to-Vortex memory bridge.
package vx_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } sub_state_t;

endpackage

// File: rtl/vx_ahb_if.sv
// AHB-Lite subordinate bus plus the Vortex-style mem_req/mem_rsp port, bundled
// so the bridge and its environment connect through one port each.
interface vx_ahb_if #(
    parameter int VX_DATA_WIDTH  = 512,
    parameter int VX_ADDR_WIDTH  = 26,
    parameter int VX_TAG_WIDTH   = 8,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int AHB_ADDR_WIDTH = 32
);
    logic                        HSEL;
    logic [AHB_ADDR_WIDTH-1:0]   HADDR;
    logic [1:0]                  HTRANS;
    logic [2:0]                  HSIZE;
    logic                        HWRITE;
    logic [AHB_DATA_WIDTH-1:0]   HWDATA;
    logic                        HREADY;
    logic                        HREADYOUT;
    logic                        HRESP;
    logic [AHB_DATA_WIDTH-1:0]   HRDATA;

    logic                        mem_req_valid;
    logic                        mem_req_rw;
    logic [VX_DATA_WIDTH/8-1:0]  mem_req_byteen;
    logic [VX_ADDR_WIDTH-1:0]    mem_req_addr;
    logic [VX_DATA_WIDTH-1:0]    mem_req_data;
    logic [VX_TAG_WIDTH-1:0]     mem_req_tag;
    logic                        mem_req_ready;
    logic                        mem_rsp_valid;
    logic [VX_DATA_WIDTH-1:0]    mem_rsp_data;
    logic [VX_TAG_WIDTH-1:0]     mem_rsp_tag;
    logic                        mem_rsp_ready;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA,
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA,
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready
    );

endinterface

// File: rtl/vx_ahb_byteen_gen.sv
// Maps an AHB transfer (line offset, size) to a line byte-enable mask and
// flags sizes wider than a word or addresses not aligned to the size.
module vx_ahb_byteen_gen
    import vx_ahb_pkg::*;
#(
    parameter int BYTES = 64,
    localparam int OFF_W = $clog2(BYTES)
) (
    input  logic [OFF_W-1:0] addr,
    input  logic [2:0]       size,
    output logic [BYTES-1:0] byteen,
    output logic             illegal
);

    logic [BYTES-1:0] mask;

    always_comb begin
        mask    = '0;
        illegal = 1'b0;
        case (hsize_t'(size))
            HSIZE_BYTE: mask = BYTES'(4'h1);
            HSIZE_HALF: begin
                mask    = BYTES'(4'h3);
                illegal = addr[0];
            end
            HSIZE_WORD: begin
                mask    = BYTES'(4'hF);
                illegal = |addr[1:0];
            end
            default:    illegal = 1'b1;
        endcase
        byteen = illegal ? '0 : (mask << addr);
    end

endmodule

// File: rtl/vx_ahb_subordinate.sv
// AHB-Lite subordinate that turns single byte/half/word transfers into one
// Vortex line request each, returning the addressed word lane on reads.
module vx_ahb_subordinate
    import vx_ahb_pkg::*;
#(
    parameter int VX_DATA_WIDTH  = 512,
    parameter int VX_ADDR_WIDTH  = 26,
    parameter int VX_TAG_WIDTH   = 8,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int TAG_VALUE      = 0
) (
    input  logic   clk,
    input  logic   reset,
    vx_ahb_if.slave bus
);

    localparam int BYTES    = VX_DATA_WIDTH / 8;
    localparam int OFF_W    = $clog2(BYTES);
    localparam int LANES    = VX_DATA_WIDTH / AHB_DATA_WIDTH;
    localparam int LANE_W   = $clog2(LANES);
    localparam int LANE_LSB = $clog2(AHB_DATA_WIDTH / 8);

    sub_state_t                state_q, state_d;
    logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]                size_q, size_d;
    logic                      write_q, write_d;
    logic [AHB_DATA_WIDTH-1:0] hrdata_q, hrdata_d;

    logic                      sample;
    logic                      in_illegal;
    logic [BYTES-1:0]          in_byteen;
    logic [BYTES-1:0]          q_byteen;
    logic                      q_illegal;
    logic [LANE_W-1:0]         lane;
    logic [AHB_DATA_WIDTH-1:0] rsp_word;
    logic                      req_active;
    logic                      unused_sig;

    // Live decode only decides ERR1 vs REQ; the payload comes from the latched copy.
    vx_ahb_byteen_gen #(.BYTES(BYTES)) u_in_gen (
        .addr    (bus.HADDR[OFF_W-1:0]),
        .size    (bus.HSIZE),
        .byteen  (in_byteen),
        .illegal (in_illegal)
    );

    vx_ahb_byteen_gen #(.BYTES(BYTES)) u_q_gen (
        .addr    (addr_q[OFF_W-1:0]),
        .size    (size_q),
        .byteen  (q_byteen),
        .illegal (q_illegal)
    );

    assign unused_sig = ^{bus.mem_rsp_tag, q_illegal, in_byteen};
    assign lane       = addr_q[OFF_W-1:LANE_LSB];
    assign sample     = bus.HSEL && bus.HREADY && bus.HTRANS[1];

    always_comb begin
        rsp_word = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane == LANE_W'(i)) rsp_word = bus.mem_rsp_data[i*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        hrdata_d = hrdata_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (sample) begin
                    addr_d  = bus.HADDR;
                    size_d  = bus.HSIZE;
                    write_d = bus.HWRITE;
                    state_d = in_illegal ? ST_ERR1 : ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: if (bus.mem_req_ready) state_d = write_q ? ST_DONE : ST_RSP;
            ST_RSP: begin
                if (bus.mem_rsp_valid) begin
                    hrdata_d = rsp_word;
                    state_d  = ST_DONE;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Payload is forced to zero outside REQ; write data tracks HWDATA live.
    assign req_active         = (state_q == ST_REQ);
    assign bus.mem_req_valid  = req_active;
    assign bus.mem_req_rw     = req_active && write_q;
    assign bus.mem_req_byteen = req_active ? q_byteen : '0;
    assign bus.mem_req_addr   = req_active ? addr_q[AHB_ADDR_WIDTH-1:OFF_W] : '0;
    assign bus.mem_req_data   = (req_active && write_q) ? {LANES{bus.HWDATA}} : '0;
    assign bus.mem_req_tag    = VX_TAG_WIDTH'(TAG_VALUE);
    assign bus.mem_rsp_ready  = (state_q == ST_RSP);

    assign bus.HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
    assign bus.HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.HRDATA    = hrdata_q;

endmodule

// File: tb/tb_vx_ahb_subordinate.sv
// Scoreboard bench for vx_ahb_subordinate: directed AHB transfers queue their
// expected memory requests and AHB completions; monitors compare as they appear.
module tb_vx_ahb_subordinate;
    import vx_ahb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_ahb_if bus ();

    vx_ahb_subordinate dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.HREADY = bus.HREADYOUT;

    typedef struct {
        logic [25:0]  addr;
        logic         rw;
        logic [63:0]  byteen;
        logic [511:0] data;
    } req_exp_t;

    typedef struct {
        logic        resp;
        logic        is_rd;
        logic [31:0] rdata;
        int          waits;
    } ahb_exp_t;

    req_exp_t req_q[$];
    ahb_exp_t ahb_q[$];
    int errors = 0;
    int checks = 0;

    int           stall_left = 0;
    bit           rsp_pend = 0;
    bit           rsp_hold = 0;
    bit           stray = 0;
    logic [511:0] rsp_line;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: optional accept stall, read line returned the cycle after acceptance.
    always @(negedge clk) begin
        bus.mem_rsp_valid = stray;
        bus.mem_rsp_tag   = 8'h00;
        if (stray) bus.mem_rsp_data = rsp_line;
        if (reset) begin
            rsp_pend = 0;
        end else if (rsp_pend && !rsp_hold) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = rsp_line;
            rsp_pend = 0;
        end
        if (bus.mem_req_valid === 1'b1 && !reset) begin
            if (stall_left > 0) begin
                bus.mem_req_ready = 1'b0;
                stall_left--;
            end else begin
                bus.mem_req_ready = 1'b1;
                if (!bus.mem_req_rw) rsp_pend = 1;
            end
        end else begin
            bus.mem_req_ready = 1'b0;
        end
    end

    bit dphase = 0;
    int waits = 0;

    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            dphase = 0;
            waits  = 0;
        end else begin
            if (bus.mem_req_valid) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got request addr %0h with none expected", bus.mem_req_addr);
                end else begin
                    chk("req_addr", bus.mem_req_addr, req_q[0].addr);
                    chk("req_rw", bus.mem_req_rw, req_q[0].rw);
                    chk("req_byteen", bus.mem_req_byteen, req_q[0].byteen);
                    chk("req_tag", bus.mem_req_tag, 0);
                    if (req_q[0].rw) chk("req_data", bus.mem_req_data, req_q[0].data);
                    if (bus.mem_req_ready) void'(req_q.pop_front());
                end
            end
            if (dphase) begin
                if (ahb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dphase: got data phase with none expected");
                    dphase = 0;
                end else if (!bus.HREADYOUT) begin
                    waits++;
                    chk("wait_hresp", bus.HRESP, ahb_q[0].resp);
                    if (!ahb_q[0].is_rd) chk("wait_rsp_ready", bus.mem_rsp_ready, 0);
                end else begin
                    chk("done_hresp", bus.HRESP, ahb_q[0].resp);
                    chk("done_waits", waits, ahb_q[0].waits);
                    if (ahb_q[0].is_rd) chk("done_hrdata", bus.HRDATA, ahb_q[0].rdata);
                    void'(ahb_q.pop_front());
                    waits = 0;
                end
            end
            if (!(dphase && !bus.HREADYOUT))
                dphase = bus.HSEL && bus.HREADYOUT && bus.HTRANS[1];
        end
    end

    task automatic issue(input logic [31:0] a, input logic [2:0] sz, input logic wr, input logic [31:0] wd,
                         input logic [25:0] e_addr, input logic [63:0] e_be, input logic e_err,
                         input logic [31:0] e_rd, input int e_waits);
        req_exp_t r;
        ahb_exp_t h;
        bit ok = 0;
        if (!e_err) begin
            r.addr = e_addr; r.rw = wr; r.byteen = e_be; r.data = {16{wd}};
            req_q.push_back(r);
        end
        h.resp = e_err; h.is_rd = !wr && !e_err; h.rdata = e_rd; h.waits = e_waits;
        ahb_q.push_back(h);
        bus.HSEL = 1'b1; bus.HADDR = a; bus.HSIZE = sz; bus.HWRITE = wr; bus.HTRANS = 2'b10;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.HREADYOUT;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL addr_phase_timeout: got HREADYOUT low for 50 cycles at %0h required high", a);
        end
        bus.HWDATA = wd;
        bus.HTRANS = 2'b00;
        bus.HSEL   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ahb_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (ahb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout: got %0d pending transfers required 0", ahb_q.size());
            ahb_q.delete();
            req_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string t);
        chk({t, "_hreadyout"}, bus.HREADYOUT, 1);
        chk({t, "_hresp"}, bus.HRESP, 0);
        chk({t, "_hrdata"}, bus.HRDATA, 0);
        chk({t, "_req_valid"}, bus.mem_req_valid, 0);
        chk({t, "_rsp_ready"}, bus.mem_rsp_ready, 0);
        chk({t, "_req_rw"}, bus.mem_req_rw, 0);
        chk({t, "_req_addr"}, bus.mem_req_addr, 0);
        chk({t, "_req_byteen"}, bus.mem_req_byteen, 0);
        chk({t, "_req_data"}, bus.mem_req_data, 0);
        chk({t, "_req_tag"}, bus.mem_req_tag, 0);
    endtask

    initial begin
        bit seen = 0;
        reset = 1'b1;
        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00;
        bus.HSIZE = 3'd0; bus.HWRITE = 1'b0; bus.HWDATA = '0;
        for (int i = 0; i < 16; i++) rsp_line[i*32 +: 32] = 32'h0BAD_0000 | i;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        rsp_line[95:64] = 32'hDEAD_BEEF;
        issue(32'h0000_0048, 3'd2, 1'b0, 32'h0, 26'h1, 64'hF00, 1'b0, 32'hDEAD_BEEF, 2);
        wait_idle();

        issue(32'h0000_0107, 3'd0, 1'b1, 32'h0000_00AB, 26'h4, 64'h80, 1'b0, 32'h0, 1);
        wait_idle();

        stall_left = 5;
        issue(32'h0000_0206, 3'd1, 1'b1, 32'h1234_5678, 26'h8, 64'hC0, 1'b0, 32'h0, 6);
        wait_idle();

        issue(32'h0000_0000, 3'd3, 1'b0, 32'h0, 26'h0, 64'h0, 1'b1, 32'h0, 1);
        wait_idle();
        issue(32'h0000_0001, 3'd1, 1'b1, 32'h5555, 26'h0, 64'h0, 1'b1, 32'h0, 1);
        wait_idle();

        issue(32'h0000_0002, 3'd2, 1'b0, 32'h0, 26'h0, 64'h0, 1'b1, 32'h0, 1);
        issue(32'h0000_0044, 3'd2, 1'b0, 32'h0, 26'h1, 64'hF0, 1'b0, 32'h0BAD_0001, 2);
        wait_idle();

        rsp_line[511:480] = 32'h600D_F00D;
        issue(32'h0000_0F3C, 3'd2, 1'b0, 32'h0, 26'h3C, 64'hF000_0000_0000_0000, 1'b0, 32'h600D_F00D, 2);
        issue(32'h0000_0F40, 3'd2, 1'b1, 32'hCAFE_F00D, 26'h3D, 64'hF, 1'b0, 32'h0, 1);
        wait_idle();

        bus.HSEL = 1'b1; bus.HADDR = 32'h80; bus.HSIZE = 3'd2;
        for (int i = 0; i < 4; i++) begin
            bus.HTRANS = (i < 2) ? 2'b00 : 2'b01;
            @(negedge clk);
            #2;
            chk("idle_hreadyout", bus.HREADYOUT, 1);
            chk("idle_no_req", bus.mem_req_valid, 0);
        end
        bus.HSEL = 1'b0; bus.HTRANS = 2'b10;
        repeat (2) @(negedge clk);
        #2;
        chk("unsel_no_req", bus.mem_req_valid, 0);
        bus.HTRANS = 2'b00;
        @(posedge clk);
        #1;

        rsp_hold = 1;
        issue(32'h0000_0048, 3'd2, 1'b0, 32'h0, 26'h1, 64'hF00, 1'b0, 32'h0, 2);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #2;
            seen = bus.mem_rsp_ready;
        end
        chk("reach_rsp", seen, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        ahb_q.delete();
        req_q.delete();
        #1;
        chk_reset_vals("mid");
        @(posedge clk);
        #1;
        reset = 1'b0;
        rsp_hold = 0;
        stray = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            chk("stray_rsp_ready", bus.mem_rsp_ready, 0);
            chk("stray_hrdata", bus.HRDATA, 0);
            chk("stray_hreadyout", bus.HREADYOUT, 1);
        end
        stray = 0;
        @(posedge clk);
        #1;

        chk("req_q_empty", req_q.size(), 0);
        chk("ahb_q_empty", ahb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
